// File: rtl/l2_cache_assoc_pkg.sv
// ---------------------------------------------------------------------------
// l2_cache_assoc_pkg
// Shared types for the set-associative L2 cache: the LC-3b word and
// cacheline types used on both sides of the cache, the byte-offset width
// of a cacheline, and the controller state encoding.
// No ports (package only).
// ---------------------------------------------------------------------------
package l2_cache_assoc_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  // Number of address bits that select a byte within a 16-byte line.
  localparam int LC3B_LINE_OFFSET = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    RESP
  } lc3b_l2a_state;

endpackage

// File: rtl/l2_cache_assoc_plru.sv
// ---------------------------------------------------------------------------
// l2_plru
// Combinational tree pseudo-LRU helper. The tree is stored heap-style:
// node 0 is the root, and the children of node n are 2n+1 (left) and
// 2n+2 (right). A node bit of 0 points the victim walk left, 1 points it
// right.
// Ports:
//   tree      in  WAYS-1 : current tree bits of the addressed set
//   way       in  log2(WAYS) : way just accessed
//   tree_next out WAYS-1 : tree bits after pointing away from 'way'
//   victim    out log2(WAYS) : way selected by following the tree bits
// ---------------------------------------------------------------------------
module l2_plru #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         tree,
  input  logic [$clog2(WAYS)-1:0] way,
  output logic [WAYS-2:0]         tree_next,
  output logic [$clog2(WAYS)-1:0] victim
);

  localparam int LW = $clog2(WAYS);

  int              vic_node;
  logic            vic_bit;
  int              upd_node;
  logic            upd_bit;
  logic [LW-1:0]   upd_way;

  // Walk from the root following the stored direction bits; each level
  // contributes one bit of the victim way number, MSB first.
  always_comb begin
    vic_node = 0;
    vic_bit  = 1'b0;
    victim   = '0;
    for (int l = 0; l < LW; l++) begin
      vic_bit = 1'b0;
      for (int n = 0; n < WAYS-1; n++) begin
        if (n == vic_node) vic_bit = tree[n];
      end
      victim   = LW'({victim, vic_bit});
      vic_node = 2 * vic_node + (vic_bit ? 2 : 1);
    end
  end

  // Walk the path of the accessed way and make every node on it point to
  // the opposite subtree, so the accessed way becomes most recently used.
  always_comb begin
    tree_next = tree;
    upd_node  = 0;
    upd_bit   = 1'b0;
    upd_way   = way;
    for (int l = 0; l < LW; l++) begin
      upd_bit = upd_way[LW-1];
      for (int n = 0; n < WAYS-1; n++) begin
        if (n == upd_node) tree_next[n] = ~upd_bit;
      end
      upd_node = 2 * upd_node + (upd_bit ? 2 : 1);
      upd_way  = upd_way << 1;
    end
  end

endmodule

// File: rtl/l2_cache_assoc.sv
// ---------------------------------------------------------------------------
// l2_cache_assoc
// Write-back, write-allocate, WAYS-way set-associative L2 cache between the
// memory arbiter and physical memory. Whole 128-bit lines move on both
// sides. Replacement fills the lowest invalid way first, otherwise the
// tree pseudo-LRU way.
// Optional feature macro: L2_PERF_COUNTERS_EN (hit/miss counters; when
// undefined both counter outputs are tied to zero).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   mem_read, mem_write        : arbiter request, held until mem_resp
//   mem_address, mem_wdata     : byte address and write line
//   mem_resp, mem_rdata        : one-cycle completion pulse and read line
//   pmem_read, pmem_write      : physical memory request, held to pmem_resp
//   pmem_address, pmem_wdata   : line-aligned address and victim line
//   pmem_resp, pmem_rdata      : physical memory completion and fill line
//   eviction                   : high during a dirty writeback
//   hit_count, miss_count      : saturating performance counters
// ---------------------------------------------------------------------------
module l2_cache_assoc
  import l2_cache_assoc_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [15:0]  mem_address,
  input  logic [127:0] mem_wdata,
  output logic         mem_resp,
  output logic [127:0] mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata,
  output logic         eviction,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int LW = $clog2(WAYS);
  localparam int AW = 16 - LC3B_LINE_OFFSET;
  localparam int TW = AW - IW;

  lc3b_l2a_state state;
  lc3b_l2a_state next_state;

  logic [AW-1:0]  line_addr_q;
  lc3b_cacheline  wdata_q;
  logic           write_q;
  logic [LW-1:0]  victim_q;

  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [WAYS-2:0] plru_q  [SETS];
  logic [TW-1:0]   tag_q   [SETS][WAYS];
  lc3b_cacheline   line_q  [SETS][WAYS];

  logic [IW-1:0]  idx;
  logic [TW-1:0]  req_tag;
  logic           hit;
  logic [LW-1:0]  hit_way;
  logic           any_invalid;
  logic [LW-1:0]  inv_way;
  logic [LW-1:0]  plru_victim;
  logic [WAYS-2:0] plru_next;
  logic [LW-1:0]  vict_sel;
  logic           vict_dirty;

  // The byte offset inside a line never affects a whole-line transfer.
  logic unused_offset;
  assign unused_offset = ^mem_address[LC3B_LINE_OFFSET-1:0];

  assign idx     = line_addr_q[IW-1:0];
  assign req_tag = line_addr_q[AW-1 -: TW];

  // Tag compare and invalid-way search for the registered request. The
  // descending loop leaves the lowest-numbered invalid way selected.
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    any_invalid = 1'b0;
    inv_way     = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        any_invalid = 1'b1;
        inv_way     = LW'(w);
      end
      if (valid_q[idx][w] && (tag_q[idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = LW'(w);
      end
    end
  end

  l2_plru #(
    .WAYS(WAYS)
  ) u_plru (
    .tree      (plru_q[idx]),
    .way       (hit_way),
    .tree_next (plru_next),
    .victim    (plru_victim)
  );

  assign vict_sel   = any_invalid ? inv_way : plru_victim;
  assign vict_dirty = valid_q[idx][vict_sel] & dirty_q[idx][vict_sel];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic. After a fill the controller re-enters LOOKUP, which
  // then hits, so responses always come from the array.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mem_read || mem_write) next_state = LOOKUP;
      LOOKUP: begin
        if (hit)             next_state = RESP;
        else if (vict_dirty) next_state = WB;
        else                 next_state = FILL;
      end
      WB:      if (pmem_resp) next_state = FILL;
      FILL:    if (pmem_resp) next_state = LOOKUP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded purely from state so that an asynchronous reset
  // drops every physical memory request at once.
  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    eviction     = 1'b0;
    case (state)
      WB: begin
        pmem_write   = 1'b1;
        eviction     = 1'b1;
        pmem_address = {tag_q[idx][victim_q], idx, {LC3B_LINE_OFFSET{1'b0}}};
        pmem_wdata   = line_q[idx][victim_q];
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, idx, {LC3B_LINE_OFFSET{1'b0}}};
      end
      RESP: begin
        mem_resp  = 1'b1;
        mem_rdata = line_q[idx][hit_way];
      end
      default: ;
    endcase
  end

  // Request capture in IDLE; a simultaneous read and write is a write.
  // The victim is frozen in LOOKUP so WB and FILL target the same way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_addr_q <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      victim_q    <= '0;
    end else begin
      if (state == IDLE && (mem_read || mem_write)) begin
        line_addr_q <= mem_address[15:LC3B_LINE_OFFSET];
        wdata_q     <= mem_wdata;
        write_q     <= mem_write;
      end
      if (state == LOOKUP && !hit) victim_q <= vict_sel;
    end
  end

  // Valid, dirty and PLRU state, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (state == FILL && pmem_resp) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
      if (state == RESP) begin
        plru_q[idx] <= plru_next;
        if (write_q) dirty_q[idx][hit_way] <= 1'b1;
      end
    end
  end

  // Tag and line storage. Contents are qualified by the valid bits, so
  // these arrays carry no reset.
  always_ff @(posedge clk) begin
    if (state == FILL && pmem_resp) begin
      tag_q[idx][victim_q]  <= req_tag;
      line_q[idx][victim_q] <= pmem_rdata;
    end
    if (state == RESP && write_q) begin
      line_q[idx][hit_way] <= wdata_q;
    end
  end

`ifdef L2_PERF_COUNTERS_EN
  logic        first_q;
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  // Only the first LOOKUP of a request is counted; the LOOKUP that follows
  // a fill is the tail of the same miss, not a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (state == IDLE && (mem_read || mem_write)) first_q <= 1'b1;
      if (state == LOOKUP) begin
        first_q <= 1'b0;
        if (first_q) begin
          if (hit && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'd1;
          if (!hit && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l2_cache_assoc.sv
// ---------------------------------------------------------------------------
// tb_l2_cache_assoc
// Directed testbench for l2_cache_assoc (WAYS=4, SETS=8). A behavioural
// physical memory answers every request after a fixed number of cycles and
// logs each completed transfer. Counter expectations follow the
// L2_PERF_COUNTERS_EN macro.
// ---------------------------------------------------------------------------
module tb_l2_cache_assoc;

  localparam int PMEM_LAT = 3;

  logic         clk;
  logic         rst_n;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_resp;
  logic [127:0] mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         eviction;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  typedef struct packed {
    logic         wr;
    logic         ev;
    logic [15:0]  a;
    logic [127:0] d;
  } txn_t;

  txn_t         log_q[$];
  logic [127:0] bmem [logic [15:0]];
  logic         overlap_seen;
  int           total;
  int           bad;

  l2_cache_assoc #(
    .WAYS(4),
    .SETS(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_resp     (mem_resp),
    .mem_rdata    (mem_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .eviction     (eviction),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Default content of a never-written line.
  function automatic logic [127:0] pat(input logic [15:0] a);
    return {a, ~a, a ^ 16'h1234, 16'hCAFE, a + 16'h0001, 16'hBEEF, ~a ^ 16'h00FF, 16'h0F0F};
  endfunction

  function automatic logic [127:0] mem_line(input logic [15:0] a);
    if (bmem.exists(a)) return bmem[a];
    return pat(a);
  endfunction

  function automatic txn_t log_at(input int i);
    if (log_q.size() > i) return log_q[i];
    return '0;
  endfunction

  // Physical memory: responds PMEM_LAT cycles after a request is seen.
  initial begin : pmem_model
    int   cnt;
    txn_t t;
    cnt          = 0;
    pmem_resp    = 1'b0;
    pmem_rdata   = '0;
    overlap_seen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) overlap_seen = 1'b1;
      if (!rst_n) cnt = 0;
      else if (pmem_read || pmem_write) begin
        if (cnt == PMEM_LAT-1) begin
          cnt       = 0;
          pmem_resp = 1'b1;
          t.wr = pmem_write;
          t.ev = eviction;
          t.a  = pmem_address;
          if (pmem_write) begin
            bmem[pmem_address] = pmem_wdata;
            t.d = pmem_wdata;
          end else begin
            pmem_rdata = mem_line(pmem_address);
            t.d = pmem_rdata;
          end
          log_q.push_back(t);
        end else begin
          cnt++;
        end
      end else cnt = 0;
    end
  end

  // Issues one request (called #1 after a rising edge) and waits for
  // mem_resp; lat counts the cycles before the response cycle.
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [127:0] wd, output logic [127:0] rdata,
                        output int lat);
    logic got;
    got   = 1'b0;
    lat   = -1;
    rdata = '0;
    mem_read    = rd;
    mem_write   = wr;
    mem_address = a;
    mem_wdata   = wd;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_resp) begin
        got   = 1'b1;
        lat   = i;
        rdata = mem_rdata;
        break;
      end
    end
    total++;
    if (got !== 1'b1) begin
      bad++;
      $display("[TB] FAIL resp_timeout addr=%h: got no mem_resp, required one within 100 cycles", a);
    end
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (mem_resp !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_resp: got %b required 0", mem_resp); end
    total++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin bad++; $display("[TB] FAIL rst_pmem_req: got %b%b required 00", pmem_read, pmem_write); end
    total++; if (pmem_address !== 16'h0 || eviction !== 1'b0) begin bad++; $display("[TB] FAIL rst_addr_ev: got %h/%b required 0000/0", pmem_address, eviction); end
    total++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin bad++; $display("[TB] FAIL rst_counters: got %h/%h required 0/0", hit_count, miss_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_read_miss_hit();
    logic [127:0] rd;
    int           lat;
    log_q.delete();
    do_req(1'b1, 1'b0, 16'h0040, '0, rd, lat);
    total++; if (lat !== 6) begin bad++; $display("[TB] FAIL miss_latency: got %0d required 6", lat); end
    total++; if (rd !== pat(16'h0040)) begin bad++; $display("[TB] FAIL miss_rdata: got %h required %h", rd, pat(16'h0040)); end
    total++; if (log_q.size() !== 1 || log_at(0).wr !== 1'b0 || log_at(0).a !== 16'h0040) begin bad++; $display("[TB] FAIL miss_pmem: got n=%0d wr=%b a=%h required n=1 wr=0 a=0040", log_q.size(), log_at(0).wr, log_at(0).a); end
    do_req(1'b1, 1'b0, 16'h0040, '0, rd, lat);
    total++; if (lat !== 2) begin bad++; $display("[TB] FAIL hit_latency: got %0d required 2", lat); end
    total++; if (rd !== pat(16'h0040)) begin bad++; $display("[TB] FAIL hit_rdata: got %h required %h", rd, pat(16'h0040)); end
    total++; if (log_q.size() !== 1) begin bad++; $display("[TB] FAIL hit_no_pmem: got n=%0d required 1", log_q.size()); end
  endtask

  // Set 0 holds 0x0000/0x0080/0x0100/0x0180 in ways 0..3; touching 0x0000
  // again leaves the tree pointing at way 2 (0x0100) as the victim.
  task automatic test_plru();
    logic [127:0] rd;
    int           lat;
    logic [15:0]  fill_addrs [4];
    fill_addrs = '{16'h0000, 16'h0080, 16'h0100, 16'h0180};
    for (int i = 0; i < 4; i++) do_req(1'b1, 1'b0, fill_addrs[i], '0, rd, lat);
    do_req(1'b1, 1'b0, 16'h0000, '0, rd, lat);
    total++; if (lat !== 2) begin bad++; $display("[TB] FAIL plru_touch_hit: got %0d required 2", lat); end
    log_q.delete();
    do_req(1'b1, 1'b0, 16'h0200, '0, rd, lat);
    total++; if (log_q.size() !== 1 || log_at(0).wr !== 1'b0 || log_at(0).a !== 16'h0200) begin bad++; $display("[TB] FAIL plru_fill_seq: got n=%0d wr=%b a=%h required n=1 wr=0 a=0200", log_q.size(), log_at(0).wr, log_at(0).a); end
    do_req(1'b1, 1'b0, 16'h0180, '0, rd, lat);
    total++; if (lat !== 2) begin bad++; $display("[TB] FAIL plru_keep_0180: got %0d required 2", lat); end
    log_q.delete();
    do_req(1'b1, 1'b0, 16'h0100, '0, rd, lat);
    total++; if (lat !== 6 || log_at(0).a !== 16'h0100) begin bad++; $display("[TB] FAIL plru_victim_0100: got lat=%0d a=%h required lat=6 a=0100", lat, log_at(0).a); end
    do_req(1'b1, 1'b0, 16'h0000, '0, rd, lat);
    total++; if (lat !== 2) begin bad++; $display("[TB] FAIL plru_keep_0000: got %0d required 2", lat); end
  endtask

  // After reset: write W to 0x0100 (way 0), fill ways 1..3, then 0x0200
  // evicts the dirty way 0.
  task automatic test_write_evict();
    logic [127:0] rd;
    logic [127:0] w_line;
    int           lat;
    logic [15:0]  fill_addrs [3];
    w_line     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    fill_addrs = '{16'h0000, 16'h0080, 16'h0180};
    do_req(1'b0, 1'b1, 16'h0100, w_line, rd, lat);
    total++; if (lat !== 6) begin bad++; $display("[TB] FAIL wr_miss_latency: got %0d required 6", lat); end
    for (int i = 0; i < 3; i++) do_req(1'b1, 1'b0, fill_addrs[i], '0, rd, lat);
    log_q.delete();
    do_req(1'b1, 1'b0, 16'h0200, '0, rd, lat);
    total++; if (lat !== 9) begin bad++; $display("[TB] FAIL dirty_latency: got %0d required 9", lat); end
    total++; if (log_q.size() !== 2) begin bad++; $display("[TB] FAIL evict_count: got %0d transfers required 2", log_q.size()); end
    total++; if (log_at(0).wr !== 1'b1 || log_at(0).ev !== 1'b1 || log_at(0).a !== 16'h0100) begin bad++; $display("[TB] FAIL evict_write: got wr=%b ev=%b a=%h required wr=1 ev=1 a=0100", log_at(0).wr, log_at(0).ev, log_at(0).a); end
    total++; if (log_at(0).d !== w_line) begin bad++; $display("[TB] FAIL evict_wdata: got %h required %h", log_at(0).d, w_line); end
    total++; if (log_at(1).wr !== 1'b0 || log_at(1).a !== 16'h0200 || rd !== pat(16'h0200)) begin bad++; $display("[TB] FAIL evict_fill: got wr=%b a=%h rd=%h required wr=0 a=0200 rd=%h", log_at(1).wr, log_at(1).a, rd, pat(16'h0200)); end
    do_req(1'b1, 1'b0, 16'h0100, '0, rd, lat);
    total++; if (lat !== 6 || rd !== w_line) begin bad++; $display("[TB] FAIL evict_reread: got lat=%0d rd=%h required lat=6 rd=%h", lat, rd, w_line); end
  endtask

  task automatic test_both_high();
    logic [127:0] rd;
    logic [127:0] x_line;
    int           lat;
    x_line = 128'hA5A5_0000_1111_2222_3333_4444_5555_5A5A;
    do_req(1'b1, 1'b1, 16'h0300, x_line, rd, lat);
    do_req(1'b1, 1'b0, 16'h0300, '0, rd, lat);
    total++; if (lat !== 2 || rd !== x_line) begin bad++; $display("[TB] FAIL both_high_write: got lat=%0d rd=%h required lat=2 rd=%h", lat, rd, x_line); end
  endtask

  task automatic test_reset_mid_fill();
    logic [127:0] rd;
    int           lat;
    logic         seen;
    seen        = 1'b0;
    mem_read    = 1'b1;
    mem_address = 16'h0050;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pmem_read) begin
        seen = 1'b1;
        break;
      end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL fill_start: got no pmem_read, required one within 20 cycles"); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (pmem_read !== 1'b0 || pmem_address !== 16'h0) begin bad++; $display("[TB] FAIL rst_in_fill: got pmem_read=%b addr=%h required 0/0000", pmem_read, pmem_address); end
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    log_q.delete();
    do_req(1'b1, 1'b0, 16'h0050, '0, rd, lat);
    total++; if (lat !== 6 || log_at(0).a !== 16'h0050 || rd !== pat(16'h0050)) begin bad++; $display("[TB] FAIL post_rst_miss: got lat=%0d a=%h rd=%h required lat=6 a=0050 rd=%h", lat, log_at(0).a, rd, pat(16'h0050)); end
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, 1'b0, 16'h0050, '0, rd, lat);
      total++; if (lat !== 2) begin bad++; $display("[TB] FAIL post_rst_hit%0d: got %0d required 2", i, lat); end
    end
  endtask

  task automatic test_counters();
    logic [15:0] exp_hit;
    logic [15:0] exp_miss;
`ifdef L2_PERF_COUNTERS_EN
    exp_hit  = 16'd3;
    exp_miss = 16'd1;
`else
    exp_hit  = 16'd0;
    exp_miss = 16'd0;
`endif
    total++; if (hit_count !== exp_hit) begin bad++; $display("[TB] FAIL hit_count: got %0d required %0d", hit_count, exp_hit); end
    total++; if (miss_count !== exp_miss) begin bad++; $display("[TB] FAIL miss_count: got %0d required %0d", miss_count, exp_miss); end
    total++; if (overlap_seen !== 1'b0) begin bad++; $display("[TB] FAIL pmem_overlap: got %b required 0", overlap_seen); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_read_miss_hit();
    test_plru();
    do_reset();
    test_write_evict();
    test_both_high();
    test_reset_mid_fill();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_cache_assoc.md
# l2_cache_assoc

Parametrised, write-back, write-allocate, N-way set-associative L2 cache placed between the memory arbiter and physical memory. It replaces the fixed-geometry L2 control/datapath pair with a single block whose way count and set count are compile-time parameters. It adds tree pseudo-LRU replacement, invalid-way-first victim selection, and optional hit/miss performance counters. Both sides use full-cacheline transfers on the existing `lc3b_word` / `lc3b_cacheline` handshake.

## Interface
- `WAYS`, 4: associativity; power of two, 2..8.
- `SETS`, 8: number of sets; power of two, 2..64.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `mem_read` in 1: arbiter read request; held until `mem_resp`.
- `mem_write` in 1: arbiter write request; held until `mem_resp`.
- `mem_address` in 16: byte address (`lc3b_word`).
- `mem_wdata` in 128: write line (`lc3b_cacheline`).
- `mem_resp` out 1: one-cycle completion pulse.
- `mem_rdata` out 128: read line; valid while `mem_resp` is high.
- `pmem_read`, `pmem_write` out 1: physical memory requests; held until `pmem_resp`.
- `pmem_address` out 16: line-aligned physical address.
- `pmem_wdata` out 128: victim line.
- `pmem_resp` in 1: physical memory completion.
- `pmem_rdata` in 128: fill line.
- `eviction` out 1: high while a dirty writeback is in progress.
- `hit_count`, `miss_count` out 16: performance counters (see Configuration).

## Operation
- Address split:
  - offset = `mem_address[3:0]`, ignored.
  - index = next `log2(SETS)` bits.
  - tag = remaining upper bits.
- Per way and set: valid bit, dirty bit, tag, 128-bit line. Per set: `WAYS-1` PLRU tree bits.
- FSM states: IDLE, LOOKUP, WB, FILL, RESP.
- IDLE: on `mem_read|mem_write`, register address, wdata and operation, then go to LOOKUP. If both are high, treat as a write.
- LOOKUP:
  - Hit goes to RESP.
  - Miss selects a victim: the lowest-index invalid way, otherwise the PLRU way.
  - Dirty victim goes to WB; clean or invalid victim goes to FILL.
  - The victim is latched in LOOKUP.
- WB:
  - `pmem_write=1`, `eviction=1`.
  - `pmem_address` = {victim tag, index, 4'b0}; `pmem_wdata` = victim line.
  - On `pmem_resp`, go to FILL.
- FILL:
  - `pmem_read=1`, `pmem_address` = {req tag, index, 4'b0}.
  - On `pmem_resp`, write `pmem_rdata` into the victim way and set valid=1, dirty=0, tag=req tag.
  - Return to LOOKUP, which now hits.
- RESP:
  - `mem_resp=1`.
  - Read: `mem_rdata` = hit line.
  - Write: the hit line is replaced by the registered wdata and dirty is set on this edge.
  - PLRU is updated to point away from the hit way.
  - Next state is IDLE.
- A miss counts once, at the first LOOKUP only. The re-LOOKUP after FILL is not counted as a hit.

## Timing
- Reset: all outputs are 0, all valid/dirty/PLRU bits are 0, FSM goes to IDLE, counters are 0. Line/tag arrays need no reset.
- Reset asserted mid-WB or mid-FILL abandons the transaction immediately; `pmem_*` drop asynchronously.
- Hit latency: request seen in IDLE at cycle 0, LOOKUP at cycle 1, `mem_resp` at cycle 2.
- Clean-miss latency: 3 + Fmem cycles.
- Dirty-miss latency: 3 + Wmem + Fmem cycles.
- The arbiter drops its request on the edge that samples `mem_resp`. IDLE may accept a new request in the cycle immediately after RESP.
- `pmem_read` and `pmem_write` are never high together. `pmem_address` is stable for the whole request.
- `pmem_resp` arriving outside WB/FILL is ignored.
- Counters saturate at 16'hFFFF.

## Configuration
- `L2_PERF_COUNTERS_EN` defined: `hit_count` increments on each first-LOOKUP hit; `miss_count` increments on each first-LOOKUP miss.
- Not defined: both outputs are constant 0, with no counter flops.

## Structure
- Add to `lc3b_types`:
  - `lc3b_l2a_state` enum (IDLE, LOOKUP, WB, FILL, RESP).
  - Line-offset constant (4).
- Sub-module `l2_plru`, parametrised by `WAYS`:
  - Input: tree bits and accessed way. Output: updated tree bits.
  - Input: tree bits. Output: victim way.
  - Purely combinational; it is instantiated once.

## Test plan
- Read 0x0040 on an empty cache, with pmem returning line L after 3 cycles -> `pmem_read` to address 0x0040, then `mem_resp` with `mem_rdata`=L. A repeat read hits with `mem_resp` at cycle 2 and no pmem activity.
- With `WAYS=4`, fill 4 tags into set 0, then read a 5th tag -> victim is the PLRU way, confirmed by the `pmem_read` address sequence and by which tag misses on re-read.
- Write line W to 0x0100, then force eviction of that set -> `eviction=1`, `pmem_write` with address 0x0100 and `pmem_wdata`=W occurs before `pmem_read` of the new tag.
- `mem_read` and `mem_write` both high -> treated as a write; a subsequent read returns `mem_wdata`.
- Assert `rst_n=0` during FILL -> `pmem_read`=0 immediately. The next read of the same address misses.
- With `L2_PERF_COUNTERS_EN` defined, 1 miss followed by 3 hits -> `miss_count`=1, `hit_count`=3. Without it, both read 0.
